quad_encoder_counter: RTL

//  N_CH-channel quadrature (A/B/Z) incremental-encoder decoder; successor to the single-channel encoder input stage.
//  Per channel: synchroniser, glitch filter, x1/x2/x4 decode, signed position counter, Z-index latch/clear, error flag.

---
 rtl/enc_pkg.sv | 25 ++
 rtl/quad_encoder_channel.sv | 191 +++++++++++++++++++
 rtl/quad_encoder_counter.sv | 54 +++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and the quadrature transition lookup used by every
// encoder channel.
package enc_pkg;

    // Decode modes (I_MODE encoding); 2'b11 also selects x4.
    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    // Classifies a previous/current {A,B} pair.
    // Returns {up, down}; both 0 for no change or an illegal double change.
    // Up sequence (A leads): 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] ab_step(input logic [1:0] prev_ab,
                                           input logic [1:0] cur_ab);
        logic [1:0] res;
        res = 2'b00;
        case ({prev_ab, cur_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: res = 2'b10;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: res = 2'b01;
            default:                            res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One quadrature encoder channel: input synchroniser, per-signal glitch
// filter, x1/x2/x4 decode, wrapping signed position counter, Z-index
// latch/clear and sticky illegal-transition flag.
module quad_encoder_channel
    import enc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             enc_z_i,
    input  logic [1:0]       mode_i,
    input  logic             z_clr_en_i,
    input  logic             cnt_clr_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             dir_o,
    output logic             step_o,
    output logic [CNT_W-1:0] z_pos_o,
    output logic             z_seen_o,
    output logic             err_o
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0]   F_ONE   = FCW'(1);
    localparam logic [FCW-1:0]   F_LEN   = FCW'(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit 0 = A, bit 1 = B, bit 2 = Z throughout the input path.
    logic [2:0] raw;
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] synced;
    logic [2:0] filt;

    assign raw    = {enc_z_i, enc_b_i, enc_a_i};
    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability shift chain for A, B and Z.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Independent glitch filter per signal: a new level is accepted once it
    // has been seen FILT_LEN samples in a row; a sample equal to the current
    // output restarts the run.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_filt
            logic           filt_q, filt_d;
            logic [FCW-1:0] fcnt_q, fcnt_d;

            // Next-state for the run counter and accepted level.
            always_comb begin
                filt_d = filt_q;
                fcnt_d = '0;
                if (synced[gi] != filt_q) begin
                    if (fcnt_q + F_ONE == F_LEN) begin
                        filt_d = synced[gi];
                    end else begin
                        fcnt_d = fcnt_q + F_ONE;
                    end
                end
            end

            // Filter state register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filt_q <= 1'b0;
                    fcnt_q <= '0;
                end else begin
                    filt_q <= filt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            assign filt[gi] = filt_q;
        end
    endgenerate

    logic [1:0]       prev_ab_q;
    logic             z_prev_q;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] z_pos_q, z_pos_d;
    logic             z_seen_q, z_seen_d;
    logic             dir_q, dir_d;
    logic             step_q;
    logic             err_q, err_d;

    logic [1:0] cur_ab;
    logic [1:0] ud;
    logic       a_chg, b_chg, illegal, z_rise;
    logic       step, step_up;

    assign cur_ab  = {filt[0], filt[1]};
    assign a_chg   = prev_ab_q[1] ^ cur_ab[1];
    assign b_chg   = prev_ab_q[0] ^ cur_ab[0];
    assign illegal = a_chg & b_chg;
    assign ud      = ab_step(prev_ab_q, cur_ab);
    assign z_rise  = filt[2] & ~z_prev_q;

    // Step qualification for the selected decode mode.
    always_comb begin
        step    = 1'b0;
        step_up = 1'b0;
        case (mode_i)
            MODE_X1: begin
                if (!prev_ab_q[1] && cur_ab[1] && !b_chg) begin
                    step    = 1'b1;
                    step_up = ~cur_ab[0];
                end
            end
            MODE_X2: begin
                if (a_chg && !b_chg) begin
                    step    = 1'b1;
                    step_up = ud[1];
                end
            end
            default: begin
                step    = ud[1] | ud[0];
                step_up = ud[1];
            end
        endcase
    end

    // Position, index latch, direction and error next-state with
    // priority counter clear > Z clear > step.
    always_comb begin
        pos_d    = pos_q;
        z_pos_d  = z_pos_q;
        z_seen_d = z_seen_q;
        dir_d    = dir_q;
        err_d    = err_q;

        if (step) begin
            pos_d = step_up ? pos_q + CNT_ONE : pos_q - CNT_ONE;
            dir_d = step_up;
        end
        if (z_rise && z_clr_en_i) pos_d = '0;
        if (cnt_clr_i) pos_d = '0;

        if (cnt_clr_i) begin
            z_seen_d = 1'b0;
        end else if (z_rise) begin
            z_pos_d  = pos_d;
            z_seen_d = 1'b1;
        end

        // A same-cycle illegal transition beats the clear request.
        if (illegal)        err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
    end

    // Decode and counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab_q <= '0;
            z_prev_q  <= 1'b0;
            pos_q     <= '0;
            z_pos_q   <= '0;
            z_seen_q  <= 1'b0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            prev_ab_q <= cur_ab;
            z_prev_q  <= filt[2];
            pos_q     <= pos_d;
            z_pos_q   <= z_pos_d;
            z_seen_q  <= z_seen_d;
            dir_q     <= dir_d;
            step_q    <= step;
            err_q     <= err_d;
        end
    end

    assign pos_o    = pos_q;
    assign dir_o    = dir_q;
    assign step_o   = step_q;
    assign z_pos_o  = z_pos_q;
    assign z_seen_o = z_seen_q;
    assign err_o    = err_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Multi-channel quadrature encoder decoder: one independent channel per
// encoder, outputs packed channel-major onto flat buses.
module quad_encoder_counter
    import enc_pkg::*;
#(
    parameter int N_CH        = 1,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                  I_CLK_100MHZ,
    input  logic                  I_RST,
    input  logic [N_CH-1:0]       I_ENC_A,
    input  logic [N_CH-1:0]       I_ENC_B,
    input  logic [N_CH-1:0]       I_ENC_Z,
    input  logic [1:0]            I_MODE,
    input  logic [N_CH-1:0]       I_Z_CLR_EN,
    input  logic [N_CH-1:0]       I_CNT_CLR,
    input  logic [N_CH-1:0]       I_ERR_CLR,
    output logic [N_CH*CNT_W-1:0] O_POS,
    output logic [N_CH-1:0]       O_DIR,
    output logic [N_CH-1:0]       O_STEP,
    output logic [N_CH*CNT_W-1:0] O_Z_POS,
    output logic [N_CH-1:0]       O_Z_SEEN,
    output logic [N_CH-1:0]       O_ERR
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            quad_encoder_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_ch (
                .clk        (I_CLK_100MHZ),
                .rst        (I_RST),
                .enc_a_i    (I_ENC_A[gi]),
                .enc_b_i    (I_ENC_B[gi]),
                .enc_z_i    (I_ENC_Z[gi]),
                .mode_i     (I_MODE),
                .z_clr_en_i (I_Z_CLR_EN[gi]),
                .cnt_clr_i  (I_CNT_CLR[gi]),
                .err_clr_i  (I_ERR_CLR[gi]),
                .pos_o      (O_POS[gi*CNT_W +: CNT_W]),
                .dir_o      (O_DIR[gi]),
                .step_o     (O_STEP[gi]),
                .z_pos_o    (O_Z_POS[gi*CNT_W +: CNT_W]),
                .z_seen_o   (O_Z_SEEN[gi]),
                .err_o      (O_ERR[gi])
            );
        end
    endgenerate

endmodule
